// File: rtl/heap_array_allocator_if.sv
// Request/response and heap-write bundle for heap_array_allocator.
//
// Signals:
//   req_valid/req_free/req_array  request from the engine (alloc when req_free=0).
//   req_ready                     allocator can take a request this cycle.
//   resp_valid/resp_array/resp_error
//                                 one-cycle completion pulse with result.
//   heap_we/heap_addr/heap_data   heap write port used to zero a new array.
//
// Modports:
//   slave  - the allocator.
//   master - the requesting engine / heap.
interface heap_array_allocator_if #(
  parameter int MemoryElementWidth = 12,
  parameter int HeapAddrWidth      = 7
);
  logic                          req_valid;
  logic                          req_free;
  logic [MemoryElementWidth-1:0] req_array;
  logic                          req_ready;
  logic                          resp_valid;
  logic [MemoryElementWidth-1:0] resp_array;
  logic                          resp_error;
  logic                          heap_we;
  logic [HeapAddrWidth-1:0]      heap_addr;
  logic [MemoryElementWidth-1:0] heap_data;

  modport slave (
    input  req_valid, req_free, req_array,
    output req_ready, resp_valid, resp_array, resp_error,
    output heap_we, heap_addr, heap_data
  );

  modport master (
    output req_valid, req_free, req_array,
    input  req_ready, resp_valid, resp_array, resp_error,
    input  heap_we, heap_addr, heap_data
  );
endinterface

// File: rtl/heap_array_allocator.sv
// Allocation controller for the heap arrays of the test-program engine.
// Keeps the array-in-use bitmap, a LIFO stack of freed ids, a per-array
// size table and allocation statistics. One alloc/free request is served
// at a time; every successful alloc zeroes the array's heap area
// (NArea words starting at id*NArea) before the response is issued.
//
// Ports:
//   clock          rising-edge clock.
//   reset          asynchronous, active-high reset.
//   bus            request/response handshake and heap write port (slave).
//   size_we        write size_value into the size table at size_array.
//   size_array     size table index for both write and read.
//   size_value     size to write.
//   size_rd        combinational size table read at size_array.
//   allocs_in_use  number of arrays currently allocated.
//   allocs_max     high-water mark of allocs_in_use.
module heap_array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 20,
  parameter int NArea              = 4,
  parameter int HeapAddrWidth      = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  heap_array_allocator_if.slave         bus,
  input  logic                          size_we,
  input  logic [MemoryElementWidth-1:0] size_array,
  input  logic [MemoryElementWidth-1:0] size_value,
  output logic [MemoryElementWidth-1:0] size_rd,
  output logic [MemoryElementWidth-1:0] allocs_in_use,
  output logic [MemoryElementWidth-1:0] allocs_max
);

  localparam int IdxW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [MemoryElementWidth-1:0] NArraysW = MemoryElementWidth'(NArrays);
  localparam logic [MemoryElementWidth-1:0] LastWord = MemoryElementWidth'(NArea - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RESP  = 2'd2
  } stateT;

  stateT                         state;
  logic [NArrays-1:0]            bitmap;
  logic [MemoryElementWidth-1:0] freedStack [NArrays];
  logic [MemoryElementWidth-1:0] stackTop;
  logic [MemoryElementWidth-1:0] nextNew;
  logic [MemoryElementWidth-1:0] sizeTable [NArrays];
  logic [MemoryElementWidth-1:0] allocsInUse;
  logic [MemoryElementWidth-1:0] allocsMax;
  logic [MemoryElementWidth-1:0] curId;
  logic [MemoryElementWidth-1:0] writeIdx;
  logic                          reqReady;
  logic                          respValid;
  logic [MemoryElementWidth-1:0] respArray;
  logic                          respError;
  logic                          heapWe;
  logic [HeapAddrWidth-1:0]      heapAddr;

  logic                          allocAvail;
  logic                          allocFromStack;
  logic [MemoryElementWidth-1:0] allocId;
  logic [HeapAddrWidth-1:0]      allocBase;
  logic [MemoryElementWidth-1:0] inUseInc;
  logic                          freeInRange;
  logic                          freeOk;
  logic                          sizeInRange;

  // Pick the id an alloc would receive: most recently freed id first,
  // then the next never-used id, otherwise nothing is available.
  always_comb begin
    allocAvail     = 1'b1;
    allocFromStack = 1'b0;
    allocId        = '0;
    if (stackTop != '0) begin
      allocFromStack = 1'b1;
      allocId        = freedStack[IdxW'(stackTop - 1'b1)];
    end else if (nextNew < NArraysW) begin
      allocId = nextNew;
    end else begin
      allocAvail = 1'b0;
    end
  end

  // Request qualification and derived values used by the state machine.
  always_comb begin
    allocBase   = HeapAddrWidth'(allocId * NArea);
    inUseInc    = allocsInUse + 1'b1;
    freeInRange = (bus.req_array < NArraysW);
    freeOk      = freeInRange ? bitmap[IdxW'(bus.req_array)] : 1'b0;
    sizeInRange = (size_array < NArraysW);
  end

  // Size table read port; out-of-range indices read as zero.
  always_comb begin
    size_rd = '0;
    if (sizeInRange) begin
      size_rd = sizeTable[IdxW'(size_array)];
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_array = respArray;
  assign bus.resp_error = respError;
  assign bus.heap_we    = heapWe;
  assign bus.heap_addr  = heapAddr;
  assign bus.heap_data  = '0;
  assign allocs_in_use  = allocsInUse;
  assign allocs_max     = allocsMax;

  // Main controller. The size table write sits ahead of the state machine
  // so that an alloc clearing the same entry on the same edge overrides it.
  // Heap writes are set up on the accept edge so the NArea zeroing writes
  // occupy the cycles directly after accept, followed by the response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bitmap      <= '0;
      stackTop    <= '0;
      nextNew     <= '0;
      allocsInUse <= '0;
      allocsMax   <= '0;
      curId       <= '0;
      writeIdx    <= '0;
      reqReady    <= 1'b1;
      respValid   <= 1'b0;
      respArray   <= '0;
      respError   <= 1'b0;
      heapWe      <= 1'b0;
      heapAddr    <= '0;
      for (int i = 0; i < NArrays; i++) begin
        freedStack[i] <= '0;
        sizeTable[i]  <= '0;
      end
    end else begin
      if (size_we && sizeInRange) begin
        sizeTable[IdxW'(size_array)] <= size_value;
      end

      case (state)
        IDLE: begin
          if (bus.req_valid && reqReady) begin
            reqReady <= 1'b0;
            if (!bus.req_free) begin
              if (allocAvail) begin
                if (allocFromStack) begin
                  stackTop <= stackTop - 1'b1;
                end else begin
                  nextNew <= nextNew + 1'b1;
                end
                bitmap[IdxW'(allocId)]    <= 1'b1;
                sizeTable[IdxW'(allocId)] <= '0;
                allocsInUse <= inUseInc;
                if (inUseInc > allocsMax) begin
                  allocsMax <= inUseInc;
                end
                curId    <= allocId;
                writeIdx <= '0;
                heapWe   <= 1'b1;
                heapAddr <= allocBase;
                state    <= CLEAR;
              end else begin
                respValid <= 1'b1;
                respError <= 1'b1;
                respArray <= '0;
                state     <= RESP;
              end
            end else begin
              respValid <= 1'b1;
              respArray <= bus.req_array;
              state     <= RESP;
              if (freeOk) begin
                bitmap[IdxW'(bus.req_array)]  <= 1'b0;
                freedStack[IdxW'(stackTop)]   <= bus.req_array;
                stackTop    <= stackTop + 1'b1;
                allocsInUse <= allocsInUse - 1'b1;
                respError   <= 1'b0;
              end else begin
                respError <= 1'b1;
              end
            end
          end
        end

        CLEAR: begin
          if (writeIdx == LastWord) begin
            heapWe    <= 1'b0;
            heapAddr  <= '0;
            respValid <= 1'b1;
            respError <= 1'b0;
            respArray <= curId;
            state     <= RESP;
          end else begin
            writeIdx <= writeIdx + 1'b1;
            heapAddr <= heapAddr + 1'b1;
          end
        end

        RESP: begin
          respValid <= 1'b0;
          respError <= 1'b0;
          reqReady  <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/heap_array_allocator.md
Name: heap_array_allocator

Overview:
- Allocation controller for the heap arrays used by the test-program engine.
- Owns the array-in-use bitmap, the freed-arrays stack, the per-array size table and the allocation statistics.
- Serves one alloc/free request at a time over a valid/ready handshake.
- On every successful alloc it sequences zeroing of that array's heap area through a dedicated heap write port.

Parameters:
- MemoryElementWidth, 12, width of array ids, sizes and heap data words.
- NArrays, 20, maximum number of arrays; valid ids are 0..NArrays-1.
- NArea, 4, heap words per array; array k occupies heap addresses k*NArea .. k*NArea+NArea-1.
- HeapAddrWidth, 7, heap address width; must satisfy 2**HeapAddrWidth >= NArrays*NArea.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_free  in  1  0 = alloc, 1 = free; sampled on accept.
- req_array  in  MemoryElementWidth  array id to free; ignored for alloc.
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  one-cycle pulse: request completed.
- resp_array  out  MemoryElementWidth  id allocated or freed.
- resp_error  out  1  qualifies resp_valid: request rejected.
- heap_we  out  1  heap write strobe.
- heap_addr  out  HeapAddrWidth  heap write address.
- heap_data  out  MemoryElementWidth  heap write data; always 0.
- size_we  in  1  write size table entry size_array <= size_value.
- size_array  in  MemoryElementWidth  size table index (write and read).
- size_value  in  MemoryElementWidth  size to write.
- size_rd  out  MemoryElementWidth  combinational read of the size table at size_array.
- allocs_in_use  out  MemoryElementWidth  number of arrays currently allocated.
- allocs_max  out  MemoryElementWidth  high-water mark of allocs_in_use.

Behaviour:
- Reset (asynchronous, any state, including mid-CLEAR):
  - state IDLE; req_ready=1; resp_valid=0, resp_error=0, resp_array=0.
  - heap_we=0, heap_addr=0; allocs_in_use=0, allocs_max=0.
  - bitmap all 0; freed-stack top=0; next_new=0; all sizes 0.
  - An interrupted CLEAR is abandoned with no response.
- Accept rule: a request is accepted on a clock edge where req_valid && req_ready. req_ready=1 only in IDLE. req_free and req_array are captured at accept.
- State IDLE, on accepted alloc:
  - Freed stack non-empty: pop the top id (LIFO).
  - Otherwise, if next_new < NArrays: take next_new, then next_new+1.
  - Otherwise: no id available -> RESP with error=1 and resp_array=0.
  - On success: set the bitmap bit, size[id]<=0, allocs_in_use+1, allocs_max=max(allocs_max, new in_use); go to CLEAR with k=0.
- State CLEAR:
  - Each cycle: heap_we=1, heap_addr=id*NArea+k, heap_data=0, k+1.
  - After the k=NArea-1 write, go to RESP.
  - Exactly NArea consecutive write cycles.
- State IDLE, on accepted free:
  - Error if req_array >= NArrays or its bitmap bit is 0 (double free or never allocated); state is unchanged.
  - Otherwise: clear the bitmap bit, push the id on the freed stack, allocs_in_use-1, size untouched.
  - Go to RESP.
  - The stack cannot overflow, because only allocated ids are pushed and depth = NArrays.
- State RESP: one cycle with resp_valid=1, resp_array and resp_error set; then IDLE with req_ready=1 on the next cycle.
- Latency, measured from the accept edge:
  - successful alloc: resp_valid high in cycle NArea+1 after accept.
  - free or any error: resp_valid high in cycle 1 after accept.
  - minimum request-to-request spacing is 2 cycles (free/error) and NArea+2 cycles (alloc).
- resp_valid has no backpressure; the consumer must sample it.
- Size table:
  - size_we takes effect in any state.
  - size_we with size_array >= NArrays is ignored.
  - If size_we targets the id being allocated in the same edge as the alloc accept, the allocator's clear to 0 wins.
- All counters are MemoryElementWidth wide; no wrap is reachable because they are bounded by NArrays.

Test Plan:
- After reset, alloc three times -> resp_array 0, 1, 2, resp_error=0; each alloc shows heap_we high for 4 cycles (addresses 0-3, 4-7, 8-11); allocs_in_use=3, allocs_max=3.
- Free 1, then free 0, then alloc -> alloc returns 0 (LIFO); next alloc returns 1; next returns 3; allocs_max=3 then 4.
- Free 2 twice -> first response error=0, second error=1; allocs_in_use decrements only once.
- Free 25 with NArrays=20 -> error=1 one cycle after accept; no other state changes.
- Alloc 20 ids with no frees -> all succeed; 21st alloc gets error=1 and resp_array=0; free 7, then alloc -> returns 7.
- Write size[5]=9, read size_rd=9; free 5, realloc 5 -> size_rd=0. Assert reset during the third CLEAR cycle -> heap_we drops immediately, no resp_valid, allocs_in_use=0.
